// File: rtl/mult_tail_pipe_if.sv
// mult_tail_pipe_if
//   Bundles the signals between the multiply tail pipeline and its neighbours:
//   the M1 product input, pipeline stall/flush control, the decode-side hazard
//   port (busy mask and bypass lookup) and the writeback/trap outputs.
//   Clock and reset stay as plain ports on the module.
//
//   slave  : the tail pipeline (consumes product/control/lookup, drives hazard and writeback)
//   master : the surrounding pipeline (drives product/control/lookup, observes the rest)
interface mult_tail_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Pipeline control
    logic                   stall;
    logic                   flush;

    // Product from the M1 stage
    logic                   in_valid;
    logic [ADDR_W-1:0]      in_dst;
    logic [DATA_W-1:0]      in_result;
    logic                   in_zero;
    logic                   in_overflow;

    // Decode hazard port
    logic [ADDR_W-1:0]      lookup_reg;
    logic                   lookup_hit;
    logic [DATA_W-1:0]      lookup_data;
    logic [2**ADDR_W-1:0]   busy_mask;

    // Writeback and trap
    logic                   wb_valid;
    logic [ADDR_W-1:0]      wb_dst;
    logic [DATA_W-1:0]      wb_result;
    logic                   wb_zero;
    logic                   wb_overflow;
    logic                   ovf_exc;

    modport slave (
        input  stall, flush,
        input  in_valid, in_dst, in_result, in_zero, in_overflow,
        input  lookup_reg,
        output lookup_hit, lookup_data, busy_mask,
        output wb_valid, wb_dst, wb_result, wb_zero, wb_overflow, ovf_exc
    );

    modport master (
        output stall, flush,
        output in_valid, in_dst, in_result, in_zero, in_overflow,
        output lookup_reg,
        input  lookup_hit, lookup_data, busy_mask,
        input  wb_valid, wb_dst, wb_result, wb_zero, wb_overflow, ovf_exc
    );
endinterface

// File: rtl/mult_tail_pipe.sv
// mult_tail_pipe
//   Back end of the integer multiply pipeline (stages M2..M5). Each product
//   from M1 travels through DEPTH registered stages and is presented to
//   writeback exactly once from the oldest stage. Every stage is visible to
//   decode through a busy-register mask and a youngest-match bypass port.
//
//   Ports
//     clk    : clock, rising edge
//     reset  : synchronous, active-high; clears every stage
//     bus    : mult_tail_pipe_if.slave
//              stall/flush            pipeline control (flush wins over stall)
//              in_*                   product from M1
//              lookup_reg/hit/data    bypass query (youngest valid match)
//              busy_mask              one bit per register with a product in flight
//              wb_*                   writeback from the oldest stage
//              ovf_exc                overflow trap strobe (TRAP_ON_OVF=1 only)
//
//   Parameters
//     DATA_W       product / register width
//     ADDR_W       register-address width
//     DEPTH        number of tail stages, legal range 2..8
//     TRAP_ON_OVF  1: overflowing products trap instead of writing back
module mult_tail_pipe #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int DEPTH       = 4,
    parameter bit TRAP_ON_OVF = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    mult_tail_pipe_if.slave bus
);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              ovf;
    } stage_t;

    // s[0] is the youngest stage, s[DEPTH-1] the oldest.
    stage_t s [DEPTH];
    stage_t last;

    logic                 can_commit;
    logic                 busy_c;
    logic                 hit_c;
    logic [DATA_W-1:0]    data_c;
    logic [2**ADDR_W-1:0] mask_c;

    // Stage registers. Flush only clears the valid bits; the data fields of
    // killed stages are never observed because every output is qualified by v.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                s[k] <= '0;
            end
        end else if (bus.flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                s[k].v <= 1'b0;
            end
        end else if (!bus.stall) begin
            // A product aimed at register 0 is architecturally discarded, so it
            // enters invalid and can never become busy, bypassed or written back.
            s[0].v      <= bus.in_valid && (bus.in_dst != '0);
            s[0].dst    <= bus.in_dst;
            s[0].result <= bus.in_result;
            s[0].zero   <= bus.in_zero;
            s[0].ovf    <= bus.in_overflow;
            for (int k = 1; k < DEPTH; k++) begin
                s[k] <= s[k-1];
            end
        end
    end

    assign last = s[DEPTH-1];

    // The oldest stage may only leave on a cycle where the pipeline actually
    // advances; a stalled product therefore commits once, on the first
    // non-stalled cycle.
    assign can_commit = last.v && !bus.stall && !bus.flush;

    // Hazard view is built only from the stage registers, so there is no
    // combinational path from the M1 inputs to decode.
    always_comb begin
        mask_c = '0;
        hit_c  = 1'b0;
        data_c = '0;
        busy_c = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (s[k].v) begin
                mask_c[s[k].dst] = 1'b1;
            end
        end
        // Scan oldest to youngest so the youngest match is the one that sticks.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (s[k].v && (s[k].dst == bus.lookup_reg)) begin
                hit_c  = 1'b1;
                data_c = s[k].result;
            end
        end
        busy_c = |mask_c;
    end

    assign bus.busy_mask   = mask_c;
    assign bus.lookup_hit  = hit_c && busy_c;
    assign bus.lookup_data = data_c;

    assign bus.wb_dst      = last.dst;
    assign bus.wb_result   = last.result;
    assign bus.wb_zero     = last.zero;
    assign bus.wb_overflow = last.ovf;

    generate
        if (TRAP_ON_OVF) begin : g_trap
            assign bus.wb_valid = can_commit && !last.ovf;
            assign bus.ovf_exc  = can_commit && last.ovf;
        end else begin : g_no_trap
            assign bus.wb_valid = can_commit;
            assign bus.ovf_exc  = 1'b0;
        end
    endgenerate

endmodule
